bin_to_bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter for the display path. It converts a WIDTH-bit unsigned value into DIGITS packed decimal digits using the shift-and-add-3 (double-dabble) method, one bit per clock. It accepts values through a valid/ready input handshake and reports results with a one-cycle done pulse and an overflow flag. It sits between the value producer (counters, measurement logic) and the seven-segment digit multiplexer, and supersedes the fixed 14-bit/4-digit subtractive converter.

---
 rtl/bin_to_bcd_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per clock.
// Define BTD_BLANK_EN to blank leading zero digits with 4'hF.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic                  out_valid
);

  localparam int AW = 4 * DIGITS;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] P10  = pow10(DIGITS);
  localparam logic [63:0] VMAX = (64'd1 << WIDTH) - 64'd1;
  localparam logic        OVF_EN = (P10 <= VMAX);

  function automatic logic [AW-1:0] add3(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    logic [3:0]    d;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      r[4*k +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] fmt(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = v;
`ifdef BTD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (lead && v[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             ovfc_q, ovfc_d;
  logic [AW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic [AW-1:0]    adj;
  logic [AW-1:0]    acc_sh;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    ovfc_d  = ovfc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    adj     = add3(acc_q);
    acc_sh  = {adj[AW-2:0], sr_q[WIDTH-1]};
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sr_d    = in_data;
          acc_d   = '0;
          cnt_d   = 6'(WIDTH);
          ovfc_d  = OVF_EN && (64'(in_data) >= P10);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = acc_sh;
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - 6'd1;
        // last shift publishes the result straight from the adder path
        if (cnt_q == 6'd1) begin
          bcd_d   = fmt(acc_sh);
          ovf_d   = ovfc_q;
          vld_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      ovfc_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      ovfc_q  <= ovfc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign bcd_out   = bcd_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_q;

endmodule
